// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the serial sequence detector.
// Shifts an N-bit word out one bit per BIT_PERIOD clocks.
module serial_bit_feeder #(
  parameter int   NUM_BITS   = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   BIT_PERIOD = 1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [NUM_BITS-1:0] load_data,
  output logic                load_ready,
  output logic                serial_out,
  output logic                bit_strobe,
  output logic                busy,
  output logic                done
);

  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = $clog2(BIT_PERIOD) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
  localparam logic [PW-1:0] LAST_PER = PW'(BIT_PERIOD - 1);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_shift;
  logic [BW-1:0]       r_bit_cnt;
  logic [PW-1:0]       r_per_cnt;
  logic                r_serial;
  logic                r_strobe;
  logic                r_busy;
  logic                r_done;

  logic                w_last_per;
  logic                w_last_bit;
  logic                w_accept;
  logic                w_first;
  logic                w_next;
  logic [NUM_BITS-1:0] w_shifted;

  assign w_last_per = (r_per_cnt == LAST_PER);
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign load_ready = (r_state == IDLE) ||
                      (w_last_per && w_last_bit);
  assign w_accept   = load_valid && load_ready;

  // The active bit always sits at the outgoing end of r_shift.
  always_comb begin
    if (MSB_FIRST) begin
      w_first   = load_data[NUM_BITS-1];
      w_next    = r_shift[NUM_BITS-2];
      w_shifted = {r_shift[NUM_BITS-2:0], 1'b0};
    end else begin
      w_first   = load_data[0];
      w_next    = r_shift[1];
      w_shifted = {1'b0, r_shift[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_per_cnt <= '0;
      r_serial  <= IDLE_BIT;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_accept) begin
        // A load in SHIFT is a back-to-back word: the old one ends now.
        r_done    <= (r_state == SHIFT);
        r_state   <= SHIFT;
        r_shift   <= load_data;
        r_serial  <= w_first;
        r_strobe  <= 1'b1;
        r_busy    <= 1'b1;
        r_bit_cnt <= '0;
        r_per_cnt <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_serial <= IDLE_BIT;
            r_busy   <= 1'b0;
          end
          SHIFT: begin
            if (!w_last_per) begin
              r_per_cnt <= r_per_cnt + PW'(1);
            end else if (!w_last_bit) begin
              r_per_cnt <= '0;
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_shift   <= w_shifted;
              r_serial  <= w_next;
              r_strobe  <= 1'b1;
            end else begin
              r_done    <= 1'b1;
              r_state   <= IDLE;
              r_serial  <= IDLE_BIT;
              r_busy    <= 1'b0;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_per_cnt <= '0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_serial <= IDLE_BIT;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign serial_out = r_serial;
  assign bit_strobe = r_strobe;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: two instances
// (MSB/1-clk/idle 0 and LSB/3-clk/idle 1) share stimulus.
module tb_serial_bit_feeder;

  localparam int N   = 8;
  localparam int SZ  = 4096;
  localparam int DSZ = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   lv  = '0;
  logic [N-1:0] ld0 = '0;
  logic [N-1:0] ld1 = '0;
  logic [1:0]   rdy, so, st, bz, dn;

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  bit eb [2][SZ];
  int hd [2] = '{0, 0};
  int tl [2] = '{0, 0};
  int ed [2][DSZ];
  int dhd [2] = '{0, 0};
  int dtl [2] = '{0, 0};
  int busy_until [2] = '{-1, -1};
  int free_at [2] = '{0, 0};
  bit end_req = 1'b0;
  bit drv_to = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_bit_feeder #(
    .NUM_BITS(N), .MSB_FIRST(1'b1),
    .BIT_PERIOD(1), .IDLE_BIT(1'b0)
  ) u0 (
    .clk(clk), .rst(rst),
    .load_valid(lv[0]), .load_data(ld0),
    .load_ready(rdy[0]), .serial_out(so[0]),
    .bit_strobe(st[0]), .busy(bz[0]), .done(dn[0])
  );

  serial_bit_feeder #(
    .NUM_BITS(N), .MSB_FIRST(1'b0),
    .BIT_PERIOD(3), .IDLE_BIT(1'b1)
  ) u1 (
    .clk(clk), .rst(rst),
    .load_valid(lv[1]), .load_data(ld1),
    .load_ready(rdy[1]), .serial_out(so[1]),
    .bit_strobe(st[1]), .busy(bz[1]), .done(dn[1])
  );

  function automatic int bp(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic idle_lvl(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s u%0d cyc=%0d got=%0h exp=%0h",
                  nm, k, cyc, a, e);
  endtask

  // Model: an accepted word becomes N bits in send order,
  // one done pulse, and a busy/ready window of N*BP cycles.
  task automatic push(input int k, input logic [N-1:0] d);
    for (int i = 0; i < N; i++) begin
      eb[k][tl[k] % SZ] = (k == 0) ? d[N-1-i] : d[i];
      tl[k]++;
    end
    ed[k][dtl[k] % DSZ] = cyc + N * bp(k) + 1;
    dtl[k]++;
    busy_until[k] = cyc + N * bp(k);
    free_at[k] = cyc + N * bp(k);
  endtask

  task automatic tick(input logic [1:0] v,
                      input logic [N-1:0] d,
                      output logic [1:0] acc);
    lv = v;
    ld0 = d;
    ld1 = d;
    acc = '0;
    for (int k = 0; k < 2; k++) begin
      if (!rst && v[k] && cyc >= free_at[k]) begin
        acc[k] = 1'b1;
        push(k, d);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    logic [1:0] a;
    repeat (n) tick(2'b00, '0, a);
  endtask

  task automatic send(input logic [N-1:0] d);
    logic [1:0] pend;
    logic [1:0] a;
    int g;
    pend = 2'b11;
    g = 0;
    while (pend != 0 && g < 200) begin
      tick(pend, d, a);
      pend &= ~a;
      g++;
    end
    if (pend != 0) drv_to = 1'b1;
  endtask

  task automatic wait_free();
    int lim;
    lim = (free_at[0] > free_at[1]) ? free_at[0] : free_at[1];
    lim = lim + 3;
    while (cyc < lim) idle_n(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      busy_until[k] = -1;
      free_at[k] = 0;
    end
    idle_n(n);
    rst = 1'b0;
  endtask

  // Driver
  initial begin
    logic [1:0] a;
    logic [1:0] v;
    int r;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    send(8'hD0);
    wait_free();
    send(8'hD0);
    send(8'hFF);
    wait_free();
    send(8'hA5);
    idle_n(2);
    tick(2'b11, 8'h00, a);
    wait_free();
    send(8'h0B);
    wait_free();
    send(8'hFF);
    idle_n(3);
    do_reset(1);
    send(8'h3C);
    wait_free();
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 2));
      end else begin
        v[0] = ($urandom_range(0, 3) != 0);
        v[1] = ($urandom_range(0, 3) != 0);
        tick(v, N'($urandom), a);
      end
    end
    wait_free();
    end_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL end_timeout monitor never finished");
    $fatal(1);
  end

  // Monitor
  initial begin
    bit   act [2];
    int   held [2];
    logic cur [2];
    act = '{1'b0, 1'b0};
    held = '{0, 0};
    cur = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          hd[k] = tl[k];
          dhd[k] = dtl[k];
          act[k] = 1'b0;
        end
        chk("ready", k, rdy[k], cyc >= free_at[k]);
        chk("busy", k, bz[k], cyc <= busy_until[k]);
        if (st[k]) begin
          if (act[k]) chk("bit_len", k, held[k], bp(k));
          if (hd[k] == tl[k]) begin
            chk("strobe_unexp", k, st[k], 0);
          end else begin
            chk("bit", k, so[k], eb[k][hd[k] % SZ]);
            hd[k]++;
          end
          act[k] = 1'b1;
          held[k] = 1;
          cur[k] = so[k];
        end else if (bz[k]) begin
          chk("hold", k, so[k], cur[k]);
          held[k]++;
        end else begin
          if (act[k]) begin
            chk("bit_len", k, held[k], bp(k));
            act[k] = 1'b0;
          end
          chk("idle_lvl", k, so[k], idle_lvl(k));
        end
        if (dn[k]) begin
          if (dhd[k] == dtl[k]) begin
            chk("done_unexp", k, dn[k], 0);
          end else begin
            chk("done_cyc", k, cyc, ed[k][dhd[k] % DSZ]);
            dhd[k]++;
          end
        end else if (dhd[k] != dtl[k] &&
                     ed[k][dhd[k] % DSZ] < cyc) begin
          chk("done_missing", k, dn[k], 1);
          dhd[k]++;
        end
      end
      if (end_req) begin
        for (int k = 0; k < 2; k++) begin
          chk("bits_left", k, tl[k] - hd[k], 0);
          chk("dones_left", k, dtl[k] - dhd[k], 0);
        end
        chk("drv_timeout", 0, drv_to, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
      end
    end
  end

endmodule
